// File: rtl/calc_pkg.sv
// Shared types and codes for the calculator sequencer: FSM states, key and ALU op encodings.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    localparam logic [1:0] KEY_DIGIT = 2'b00;
    localparam logic [1:0] KEY_OP    = 2'b01;
    localparam logic [1:0] KEY_EQ    = 2'b10;
    localparam logic [1:0] KEY_CLR   = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [15:0] ERR_WORD = 16'hFFFF;

    function automatic logic is_bcd_digit(input logic [3:0] v);
        return (v <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd2bin_8bit.sv
// Combinational two-digit BCD to binary converter (00-99 -> 0-99).
module bcd2bin_8bit (
    input  logic [7:0] bcd_i,
    output logic [6:0] bin_o
);
    logic [6:0] tens;

    // tens digit * 10 built as *8 + *2
    assign tens  = ({3'b000, bcd_i[7:4]} << 3) + ({3'b000, bcd_i[7:4]} << 1);
    assign bin_o = tens + {3'b000, bcd_i[3:0]};

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator key sequencer driving an external 8-bit ALU and latching its result for display.
// Optional operator chaining from the SHOW state is enabled by defining CALC_CHAIN_EN.
module calc_seq_ctrl
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [1:0]  key_type,
    input  logic [3:0]  key_val,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_status,
    output logic [15:0] disp_value,
    output logic        disp_err,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state_o
);
    // Keys are single-cycle strobes with no back-pressure: a key seen while busy is lost.
    state_e      state_q;
    logic        exec_ph_q;
    logic [7:0]  a_q, b_q;
    logic [1:0]  op_q;
    logic [7:0]  alu_a_q, alu_b_q;
    logic [1:0]  alu_op_q;
    logic [15:0] disp_value_q;
    logic        disp_err_q;
    logic        done_q;
    logic [6:0]  a_bin, b_bin;
    logic        digit_ok, op_key, eq_key, clr_key, op_is_muldiv;

    bcd2bin_8bit u_a_conv (.bcd_i(a_q), .bin_o(a_bin));
    bcd2bin_8bit u_b_conv (.bcd_i(b_q), .bin_o(b_bin));

    assign digit_ok     = key_valid && (key_type == KEY_DIGIT) && is_bcd_digit(key_val);
    assign op_key       = key_valid && (key_type == KEY_OP);
    assign eq_key       = key_valid && (key_type == KEY_EQ);
    assign clr_key      = key_valid && (key_type == KEY_CLR);
    assign op_is_muldiv = op_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_ENTER_A;
            exec_ph_q    <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_ADD;
            disp_value_q <= '0;
            disp_err_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr_key && state_q != ST_EXEC) begin
                state_q      <= ST_ENTER_A;
                a_q          <= '0;
                b_q          <= '0;
                op_q         <= OP_ADD;
                disp_value_q <= '0;
                disp_err_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_ENTER_A: begin
                        if (digit_ok) begin
                            a_q          <= {a_q[3:0], key_val};
                            disp_value_q <= {8'h00, a_q[3:0], key_val};
                        end else if (op_key) begin
                            op_q         <= key_val[1:0];
                            b_q          <= '0;
                            disp_value_q <= '0;
                            state_q      <= ST_ENTER_B;
                        end
                    end
                    ST_ENTER_B: begin
                        if (digit_ok) begin
                            b_q          <= {b_q[3:0], key_val};
                            disp_value_q <= {8'h00, b_q[3:0], key_val};
                        end else if (op_key) begin
                            op_q <= key_val[1:0];
                        end else if (eq_key) begin
                            exec_ph_q <= 1'b0;
                            state_q   <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        if (!exec_ph_q) begin
                            // add/sub work on BCD digits, mul/div on true binary magnitudes
                            alu_a_q   <= op_is_muldiv ? {1'b0, a_bin} : a_q;
                            alu_b_q   <= op_is_muldiv ? {1'b0, b_bin} : b_q;
                            alu_op_q  <= op_q;
                            exec_ph_q <= 1'b1;
                        end else begin
                            exec_ph_q <= 1'b0;
                            done_q    <= 1'b1;
                            if (op_is_muldiv && alu_status) begin
                                disp_value_q <= ERR_WORD;
                                disp_err_q   <= 1'b1;
                                state_q      <= ST_ERROR;
                            end else begin
                                disp_value_q <= alu_result;
                                disp_err_q   <= alu_status;
                                state_q      <= ST_SHOW;
                            end
                        end
                    end
                    ST_SHOW: begin
                        if (digit_ok) begin
                            a_q          <= {4'h0, key_val};
                            disp_value_q <= {12'h000, key_val};
                            disp_err_q   <= 1'b0;
                            state_q      <= ST_ENTER_A;
                        end
`ifdef CALC_CHAIN_EN
                        else if (op_key && !disp_err_q && !op_is_muldiv) begin
                            a_q          <= disp_value_q[7:0];
                            op_q         <= key_val[1:0];
                            b_q          <= '0;
                            disp_value_q <= '0;
                            state_q      <= ST_ENTER_B;
                        end
`endif
                    end
                    ST_ERROR: begin
                    end
                    default: state_q <= ST_ENTER_A;
                endcase
            end
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign disp_value  = disp_value_q;
    assign disp_err    = disp_err_q;
    assign done        = done_q;
    assign busy        = (state_q == ST_EXEC);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with a behavioural BCD/binary ALU and a done-driven scoreboard.
module tb_calc_seq_ctrl;
    import calc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [1:0]  key_type;
    logic [3:0]  key_val;
    logic [7:0]  alu_a, alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_status;
    logic [15:0] disp_value;
    logic        disp_err;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;
    logic [15:0] prod;

    calc_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_type(key_type),
        .key_val(key_val), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_status(alu_status), .disp_value(disp_value),
        .disp_err(disp_err), .busy(busy), .done(done), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ALU: BCD add/sub with carry/borrow, binary mul (flag >255) and div (flag on /0)
    function automatic int bcd_to_int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] int_to_bcd(input int n);
        logic [15:0] r;
        r = '0;
        r[11:8] = 4'(n / 100);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    assign prod = {8'h00, alu_a} * {8'h00, alu_b};

    always_comb begin
        alu_result = '0;
        alu_status = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_result = int_to_bcd(bcd_to_int(alu_a) + bcd_to_int(alu_b));
                alu_status = (bcd_to_int(alu_a) + bcd_to_int(alu_b)) > 99;
            end
            OP_SUB: begin
                if (bcd_to_int(alu_a) >= bcd_to_int(alu_b)) begin
                    alu_result = int_to_bcd(bcd_to_int(alu_a) - bcd_to_int(alu_b));
                end else begin
                    alu_result = int_to_bcd(100 + bcd_to_int(alu_a) - bcd_to_int(alu_b));
                    alu_status = 1'b1;
                end
            end
            OP_MUL: begin
                alu_result = prod;
                alu_status = (prod > 16'd255);
            end
            default: begin
                if (alu_b == 8'h00) alu_status = 1'b1;
                else alu_result = {8'h00, alu_a / alu_b};
            end
        endcase
    end

    function automatic logic [19:0] mk(input state_e s, input logic e, input logic [15:0] d);
        return {s, e, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks (called at a negedge, return at the negedge after the consuming edge)
    task automatic press(input logic [1:0] t, input logic [3:0] v);
        key_type  = t;
        key_val   = v;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_ENTER_A));
        check({tag, "_disp"}, 32'(disp_value), 32'h0);
        check({tag, "_err"}, 32'(disp_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'h0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'h0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'h0);
    endtask

    task automatic run_exec(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                            input logic [1:0] eop, input logic [19:0] entry, input bit inject);
        exp_q.push_back(entry);
        press(KEY_EQ, 4'h0);
        check({tag, "_busy1"}, 32'(busy), 32'h1);
        if (inject) begin
            key_type  = KEY_DIGIT;
            key_val   = 4'h7;
            key_valid = 1'b1;
        end
        @(negedge clk);
        check({tag, "_alu_a"}, 32'(alu_a), 32'(ea));
        check({tag, "_alu_b"}, 32'(alu_b), 32'(eb));
        check({tag, "_alu_op"}, 32'(alu_op), 32'(eop));
        check({tag, "_busy2"}, 32'(busy), 32'h1);
        if (inject) key_type = KEY_CLR;
        @(negedge clk);
        key_valid = 1'b0;
        check({tag, "_busy_end"}, 32'(busy), 32'h0);
    endtask

    // scoreboard monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 required done=0 (no result pending)");
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_disp_value", 32'(disp_value), 32'(mon_e[15:0]));
                check("mon_disp_err", 32'(disp_err), 32'(mon_e[16]));
                check("mon_state", 32'(dbg_state), 32'(mon_e[19:17]));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_type  = KEY_DIGIT;
        key_val   = 4'h0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 45 + 38 with keys pulsed while busy, and an invalid digit in ENTER_A
        press(KEY_DIGIT, 4'h4);
        press(KEY_DIGIT, 4'h5);
        press(KEY_DIGIT, 4'hA);
        check("bad_digit_disp", 32'(disp_value), 32'h0045);
        check("bad_digit_state", 32'(dbg_state), 32'(ST_ENTER_A));
        press(KEY_OP, {2'b00, OP_ADD});
        check("op_state", 32'(dbg_state), 32'(ST_ENTER_B));
        check("op_disp", 32'(disp_value), 32'h0000);
        press(KEY_DIGIT, 4'h3);
        press(KEY_DIGIT, 4'h8);
        check("b_disp", 32'(disp_value), 32'h0038);
        run_exec("add", 8'h45, 8'h38, OP_ADD, mk(ST_SHOW, 1'b0, 16'h0083), 1'b1);
        check("add_hold_disp", 32'(disp_value), 32'h0083);
        check("add_hold_state", 32'(dbg_state), 32'(ST_SHOW));

        // 99 * 99 overflows into ERROR
        press(KEY_CLR, 4'h0);
        press(KEY_DIGIT, 4'h9); press(KEY_DIGIT, 4'h9);
        press(KEY_OP, {2'b00, OP_MUL});
        press(KEY_DIGIT, 4'h9); press(KEY_DIGIT, 4'h9);
        run_exec("mul_ovf", 8'd99, 8'd99, OP_MUL, mk(ST_ERROR, 1'b1, ERR_WORD), 1'b0);

        // 12 / 00 -> ERROR; only clear escapes
        press(KEY_CLR, 4'h0);
        check("clr_state", 32'(dbg_state), 32'(ST_ENTER_A));
        check("clr_disp", 32'(disp_value), 32'h0);
        check("clr_err", 32'(disp_err), 32'h0);
        press(KEY_DIGIT, 4'h1); press(KEY_DIGIT, 4'h2);
        press(KEY_OP, {2'b00, OP_DIV});
        press(KEY_DIGIT, 4'h0); press(KEY_DIGIT, 4'h0);
        run_exec("div0", 8'd12, 8'd0, OP_DIV, mk(ST_ERROR, 1'b1, ERR_WORD), 1'b0);
        press(KEY_DIGIT, 4'h5);
        press(KEY_OP, {2'b00, OP_ADD});
        press(KEY_EQ, 4'h0);
        check("err_ignore_state", 32'(dbg_state), 32'(ST_ERROR));
        check("err_ignore_disp", 32'(disp_value), 32'hFFFF);
        press(KEY_CLR, 4'h0);
        check("err_clr_state", 32'(dbg_state), 32'(ST_ENTER_A));
        check("err_clr_disp", 32'(disp_value), 32'h0);

        // equals in ENTER_A is ignored
        press(KEY_DIGIT, 4'h7);
        press(KEY_EQ, 4'h0);
        check("eq_a_state", 32'(dbg_state), 32'(ST_ENTER_A));
        check("eq_a_disp", 32'(disp_value), 32'h0007);

        // non-overflowing mul and div use binary operands
        press(KEY_CLR, 4'h0);
        press(KEY_DIGIT, 4'h1); press(KEY_DIGIT, 4'h2);
        press(KEY_OP, {2'b00, OP_MUL});
        press(KEY_DIGIT, 4'h1); press(KEY_DIGIT, 4'h1);
        run_exec("mul", 8'd12, 8'd11, OP_MUL, mk(ST_SHOW, 1'b0, 16'd132), 1'b0);
        press(KEY_CLR, 4'h0);
        press(KEY_DIGIT, 4'h8); press(KEY_DIGIT, 4'h4);
        press(KEY_OP, {2'b00, OP_DIV});
        press(KEY_DIGIT, 4'h1); press(KEY_DIGIT, 4'h2);
        run_exec("div", 8'd84, 8'd12, OP_DIV, mk(ST_SHOW, 1'b0, 16'd7), 1'b0);

        // op overwrite in ENTER_B, then borrow flag on 03 - 05
        press(KEY_CLR, 4'h0);
        press(KEY_DIGIT, 4'h3);
        press(KEY_OP, {2'b00, OP_ADD});
        press(KEY_OP, {2'b00, OP_SUB});
        press(KEY_DIGIT, 4'h5);
        run_exec("borrow", 8'h03, 8'h05, OP_SUB, mk(ST_SHOW, 1'b1, 16'h0098), 1'b0);
        press(KEY_DIGIT, 4'h6);
        check("show_digit_state", 32'(dbg_state), 32'(ST_ENTER_A));
        check("show_digit_disp", 32'(disp_value), 32'h0006);
        check("show_digit_err", 32'(disp_err), 32'h0);

        // 20 - 05, then an operator in SHOW
        press(KEY_CLR, 4'h0);
        press(KEY_DIGIT, 4'h2); press(KEY_DIGIT, 4'h0);
        press(KEY_OP, {2'b00, OP_SUB});
        press(KEY_DIGIT, 4'h0); press(KEY_DIGIT, 4'h5);
        run_exec("sub", 8'h20, 8'h05, OP_SUB, mk(ST_SHOW, 1'b0, 16'h0015), 1'b0);
        press(KEY_OP, {2'b00, OP_ADD});
`ifdef CALC_CHAIN_EN
        check("chain_state", 32'(dbg_state), 32'(ST_ENTER_B));
        press(KEY_DIGIT, 4'h1); press(KEY_DIGIT, 4'h0);
        run_exec("chain", 8'h15, 8'h10, OP_ADD, mk(ST_SHOW, 1'b0, 16'h0025), 1'b0);
`else
        check("nochain_state", 32'(dbg_state), 32'(ST_SHOW));
        check("nochain_disp", 32'(disp_value), 32'h0015);
        press(KEY_DIGIT, 4'h1); press(KEY_DIGIT, 4'h0);
        press(KEY_EQ, 4'h0);
        check("nochain_a_state", 32'(dbg_state), 32'(ST_ENTER_A));
        check("nochain_a_disp", 32'(disp_value), 32'h0010);
`endif

        // reset during EXEC cycle 1 aborts without a done pulse
        press(KEY_CLR, 4'h0);
        press(KEY_DIGIT, 4'h1);
        press(KEY_OP, {2'b00, OP_ADD});
        press(KEY_DIGIT, 4'h2);
        press(KEY_EQ, 4'h0);
        check("abort_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("abort");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_idle_state", 32'(dbg_state), 32'(ST_ENTER_A));

        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
